// File: rtl/sim_pkg.sv
// sim_pkg: shared widths, pipeline stage records and the absolute-difference helper for sim_arbiter.
// Contents:
//   SIM_W       operand/result width (8)
//   SIM_LAT     accept-to-response latency in cycles (3)
//   SIM_STAT_W  grant counter width (16)
//   SIM_IDW_MAX ID field width in the stage records, wide enough for NREQ up to 8
//   sim_s1_t    stage 1 record: valid, id, op1, op2
//   sim_s2_t    stage 2 record: valid, id, d
package sim_pkg;
    localparam int SIM_W       = 8;
    localparam int SIM_LAT     = 3;
    localparam int SIM_STAT_W  = 16;
    localparam int SIM_IDW_MAX = 3;

    typedef struct packed {
        logic                   valid;
        logic [SIM_IDW_MAX-1:0] id;
        logic [SIM_W-1:0]       op1;
        logic [SIM_W-1:0]       op2;
    } sim_s1_t;

    typedef struct packed {
        logic                   valid;
        logic [SIM_IDW_MAX-1:0] id;
        logic [SIM_W-1:0]       d;
    } sim_s2_t;

    // Subtracts the smaller operand from the larger one, so the result never wraps.
    function automatic logic [SIM_W-1:0] sim_absdiff(input logic [SIM_W-1:0] a, input logic [SIM_W-1:0] b);
        return (a > b) ? a - b : b - a;
    endfunction
endpackage

// File: rtl/sim_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker; grants the first valid requester at or after ptr.
// Ports:
//   req    in  NREQ  per-requester request
//   ptr    in  IDW   requester with highest priority this cycle
//   en     in  1     grant enable; low forces gnt to zero
//   gnt    out NREQ  one-hot grant (zero when disabled or idle)
//   gnt_id out IDW   encoded grant (0 when gnt is zero)
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    input  logic            en,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_id
);
    logic [IDW-1:0] w_idx;

    // Scanning from the far end down lets the requester closest to ptr win last.
    always_comb begin
        gnt_id = '0;
        w_idx  = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            w_idx = IDW'((int'(ptr) + i) % NREQ);
            if (req[w_idx]) gnt_id = w_idx;
        end
        gnt = (en && |req) ? {{(NREQ-1){1'b0}}, 1'b1} << gnt_id : '0;
    end
endmodule

// File: rtl/sim_arbiter.sv
// sim_arbiter: round-robin arbiter feeding a 3-stage similarity pipeline (res = 255 - |op1 - op2|).
// Optional feature macro: SIM_ARB_STATS_EN adds stat_clr/stat_cnt per-requester grant counters.
// Ports:
//   clk        in  1        clock, rising edge
//   rst        in  1        asynchronous active-low reset
//   en         in  1        grant enable; low blocks new grants while the pipeline drains
//   req_valid  in  NREQ     per-requester request
//   req_ready  out NREQ     one-hot grant; transfer when valid & ready
//   req_op1    in  NREQ*W   operand 1, requester i at [i*W +: W]
//   req_op2    in  NREQ*W   operand 2, same packing
//   stat_clr   in  1        clear all grant counters (SIM_ARB_STATS_EN only)
//   stat_cnt   out NREQ*16  saturating grant counters (SIM_ARB_STATS_EN only)
//   rsp_valid  out 1        one-cycle pulse per accepted op, 3 cycles after transfer
//   rsp_id     out IDW      requester ID of the result
//   rsp_res    out W        255 - |op1 - op2|
module sim_arbiter
    import sim_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int W    = SIM_W,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [NREQ-1:0]            req_valid,
    output logic [NREQ-1:0]            req_ready,
    input  logic [NREQ*W-1:0]          req_op1,
    input  logic [NREQ*W-1:0]          req_op2,
`ifdef SIM_ARB_STATS_EN
    input  logic                       stat_clr,
    output logic [NREQ*SIM_STAT_W-1:0] stat_cnt,
`endif
    output logic                       rsp_valid,
    output logic [IDW-1:0]             rsp_id,
    output logic [W-1:0]               rsp_res
);
    logic [IDW-1:0]  r_ptr;
    logic [IDW-1:0]  w_gnt_id;
    logic [IDW-1:0]  w_ptr_nxt;
    logic [NREQ-1:0] w_gnt;
    logic            w_xfer;
    sim_s1_t         r_s1;
    sim_s2_t         r_s2;
    logic            r_rsp_valid;
    logic [IDW-1:0]  r_rsp_id;
    logic [W-1:0]    r_rsp_res;

    // Gating en with the reset keeps req_ready low for the whole reset window.
    rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
        .req    (req_valid),
        .ptr    (r_ptr),
        .en     (en & rst),
        .gnt    (w_gnt),
        .gnt_id (w_gnt_id)
    );

    assign req_ready = w_gnt;
    assign w_xfer    = |w_gnt;
    assign w_ptr_nxt = (w_gnt_id == IDW'(NREQ - 1)) ? '0 : w_gnt_id + 1'b1;
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_res   = r_rsp_res;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr       <= '0;
            r_s1        <= '0;
            r_s2        <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_res   <= '0;
        end else begin
            if (w_xfer) r_ptr <= w_ptr_nxt;
            r_s1        <= '{valid: w_xfer, id: SIM_IDW_MAX'(w_gnt_id),
                             op1: req_op1[w_gnt_id*W +: W], op2: req_op2[w_gnt_id*W +: W]};
            r_s2        <= '{valid: r_s1.valid, id: r_s1.id, d: sim_absdiff(r_s1.op1, r_s1.op2)};
            r_rsp_valid <= r_s2.valid;
            // Result fields hold across bubbles; 255 - d is just the bitwise complement.
            if (r_s2.valid) begin
                r_rsp_id  <= r_s2.id[IDW-1:0];
                r_rsp_res <= ~r_s2.d;
            end
        end
    end

`ifdef SIM_ARB_STATS_EN
    logic [NREQ-1:0][SIM_STAT_W-1:0] r_cnt;

    // Clear wins over a same-cycle increment; counters stick at all-ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_cnt <= '0;
        else begin
            for (int i = 0; i < NREQ; i++) begin
                if (stat_clr) r_cnt[i] <= '0;
                else if (w_gnt[i] && r_cnt[i] != '1) r_cnt[i] <= r_cnt[i] + 1'b1;
            end
        end
    end

    assign stat_cnt = r_cnt;
`endif
endmodule

// File: doc/sim_arbiter.md
# sim_arbiter

Round-robin arbiter and sequencer sharing one similarity pipeline (res = 255 − |op1 − op2|, 8-bit unsigned) among NREQ requesters. It accepts at most one operand pair per cycle and pushes it through a fixed 3-stage pipeline. Each result returns tagged with the originating requester ID. It sits between the pixel/feature requesters and the downstream match/score logic.

## Interface
- NREQ, 4: number of requesters, 2..8.
- W, 8: operand/result width; the datapath is specified for 8.
- IDW, $clog2(NREQ): requester ID width.
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  grant enable; low blocks new grants while the pipeline drains.
- req_valid  in  NREQ  per-requester request.
- req_ready  out  NREQ  one-hot grant; transfer when valid & ready.
- req_op1  in  NREQ*W  packed operand 1, requester i at [i*W +: W].
- req_op2  in  NREQ*W  packed operand 2, same packing.
- rsp_valid  out  1  result valid, single-cycle pulse per accepted op.
- rsp_id  out  IDW  requester ID of the result.
- rsp_res  out  W  255 − |op1 − op2|.
- stat_clr  in  1  clears grant counters (only with SIM_ARB_STATS_EN).
- stat_cnt  out  NREQ*16  per-requester grant counters (only with SIM_ARB_STATS_EN).

## Operation
- Arbitration is combinational from req_valid, en and the priority pointer ptr.
- The grant goes to the first requester with req_valid=1, searching ptr, ptr+1, … mod NREQ.
- req_ready is all-zero when en=0 or no request is pending.
- After a transfer to requester g, ptr ← (g+1) mod NREQ. Without a transfer, ptr holds.
- A requester holds req_valid and operands stable until accepted. No requester is skipped while it holds valid, so the worst-case wait is NREQ−1 cycles.
- Pipeline stage 1 registers the granted op1, op2, ID and valid.
- Stage 2 computes d = (op1 > op2) ? op1 − op2 : op2 − op1 (8-bit, never negative) and carries ID/valid.
- Stage 3 registers res = 255 − d (equivalently ~d), drives rsp_*.
- Equal operands give 255. |0 − 255| gives 0.
- Responses have no backpressure. The consumer must accept every pulse.
- Bubbles propagate as valid=0. rsp_id/rsp_res hold their last values when rsp_valid=0.
- Reset values: req_ready=0 (en is don't-care under reset), rsp_valid=0, rsp_id=0, rsp_res=0, ptr=0, all pipeline valid/data=0, stat_cnt=0.

## Timing
- Latency: a transfer in cycle k gives rsp_valid=1 in cycle k+3.
- Throughput: one op per cycle sustained. There are no dead cycles between grants to different requesters.
- Deasserting en in cycle k blocks grants in cycle k. Ops already accepted still emerge over the next 3 cycles.
- Reset asserted mid-operation discards all in-flight ops immediately. No rsp_valid is produced for them after reset release.
- The first grant is possible in the first cycle after reset deassertion.
- Simultaneous requests from all NREQ requesters produce grants in strict rotation from ptr.

## Configuration
- SIM_ARB_STATS_EN defined:
  - Adds stat_clr and stat_cnt.
  - Each requester has a 16-bit counter that increments on every transfer for that requester and saturates at 0xFFFF.
  - stat_clr=1 zeroes all counters on the next edge and takes priority over a same-cycle increment.
  - Reset clears the counters.
- SIM_ARB_STATS_EN undefined: both ports and all counter logic are absent. Arbitration and datapath behaviour are identical in both builds.

## Structure
- Shared package sim_pkg:
  - SIM_W = 8
  - SIM_LAT = 3
  - SIM_STAT_W = 16
  - stage typedef struct: valid, id, op1, op2 / d
- Sub-module rr_pick: combinational round-robin picker with inputs req[NREQ], ptr and en, and outputs one-hot gnt and encoded gnt_id. The top holds ptr, the pipeline and the counters.

## Test plan
- Reset, then requester 0 only, op1=200, op2=50, accepted cycle k → rsp_valid in k+3, rsp_id=0, rsp_res=105. Then op1=50, op2=200 → 105. Then op1=op2=77 → 255.
- All four requesters valid continuously from reset → grants 0,1,2,3,0,…, one per cycle. Responses in the same order 3 cycles later, back-to-back with no bubbles.
- Requesters 1 and 3 valid with ptr=2 → grant 3, then 1. Requester 2 raising valid later is served before requester 1 returns to priority, per ptr.
- en=0 for 5 cycles while all requesters are valid → req_ready=0 throughout and the in-flight ops drain. en=1 → grants resume from the held ptr.
- Reset pulsed while 3 ops are in flight → no rsp_valid for them, outputs return to 0, and the first grant after release goes to requester 0.
- With SIM_ARB_STATS_EN: 70000 grants to requester 2 → stat_cnt[2]=0xFFFF. Asserting stat_clr in the same cycle as a grant → counter reads 0 the following cycle.
